// File: rtl/roba_a_pre_approx_pipe_if.sv
// rtl/roba_a_pre_approx_pipe_if.sv - operand-in / result-out handshake bundle for the pre-approximation pipe
interface roba_a_pre_approx_pipe_if #(
  parameter int A_BW  = 16,
  parameter int LANES = 4
);
  localparam int K_BW = $clog2(A_BW);

  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*A_BW-1:0]         in_a;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*K_BW-1:0]         out_k;
  logic [LANES*(A_BW+1)-1:0]     out_ar;
  logic [LANES-1:0]              out_zero;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_k, out_ar, out_zero
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_k, out_ar, out_zero
  );
endinterface

// File: rtl/roba_a_pre_approx_pipe.sv
// rtl/roba_a_pre_approx_pipe.sv - 2-stage per-lane leading-one index and round-to-power-of-two pipe
// Optional statistics outputs are built when ROBA_PRE_STATS_EN is defined.
module roba_a_pre_approx_pipe #(
  parameter int A_BW  = 16,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  roba_a_pre_approx_pipe_if.slave  bus
`ifdef ROBA_PRE_STATS_EN
  ,
  output logic [31:0]              stat_cnt,
  output logic [31:0]              stat_zero
`endif
);
  localparam int K_BW  = $clog2(A_BW);
  localparam int AR_BW = A_BW + 1;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*A_BW-1:0]   s1_a_q, s1_a_d;
  logic [LANES*A_BW-1:0]   s1_oh_q, s1_oh_d;
  logic [LANES*K_BW-1:0]   k_q, k_d;
  logic [LANES*AR_BW-1:0]  ar_q, ar_d;
  logic [LANES-1:0]        zero_q, zero_d;
  logic                    s1_load, s2_load;

  function automatic logic [A_BW-1:0] msb_onehot(input logic [A_BW-1:0] a);
    logic [A_BW-1:0] oh;
    oh = '0;
    for (int i = 0; i < A_BW; i++) begin
      if (a[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [K_BW-1:0] encode(input logic [A_BW-1:0] oh);
    logic [K_BW-1:0] k;
    k = '0;
    for (int i = 0; i < A_BW; i++) begin
      if (oh[i]) k = K_BW'(i);
    end
    return k;
  endfunction

  // Round up to the next power of two when the bit just below the leading one is set.
  function automatic logic [AR_BW-1:0] round_ar(input logic [A_BW-1:0] a, input logic [A_BW-1:0] oh);
    if (|(a & (oh >> 1))) return {oh, 1'b0};
    return {1'b0, oh};
  endfunction

  always_comb begin
    s2_load    = !s2_valid_q || bus.out_ready;
    s1_load    = !s1_valid_q || s2_load;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_a_d     = s1_a_q;
    s1_oh_d    = s1_oh_q;
    k_d        = k_q;
    ar_d       = ar_q;
    zero_d     = zero_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d = bus.in_a;
        for (int l = 0; l < LANES; l++) begin
          s1_oh_d[l*A_BW +: A_BW] = msb_onehot(bus.in_a[l*A_BW +: A_BW]);
        end
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          k_d[l*K_BW +: K_BW]    = encode(s1_oh_q[l*A_BW +: A_BW]);
          ar_d[l*AR_BW +: AR_BW] = round_ar(s1_a_q[l*A_BW +: A_BW], s1_oh_q[l*A_BW +: A_BW]);
          zero_d[l]              = ~|s1_oh_q[l*A_BW +: A_BW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_oh_q    <= '0;
      k_q        <= '0;
      ar_q       <= '0;
      zero_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_a_q     <= s1_a_d;
      s1_oh_q    <= s1_oh_d;
      k_q        <= k_d;
      ar_q       <= ar_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_k     = k_q;
  assign bus.out_ar    = ar_q;
  assign bus.out_zero  = zero_q;

`ifdef ROBA_PRE_STATS_EN
  logic [31:0] stat_cnt_q, stat_zero_q;
  logic [32:0] zero_sum;

  always_comb begin
    zero_sum = {1'b0, stat_zero_q};
    for (int l = 0; l < LANES; l++) begin
      zero_sum = zero_sum + 33'(zero_q[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q  <= '0;
      stat_zero_q <= '0;
    end else if (s2_valid_q && bus.out_ready) begin
      if (stat_cnt_q != '1) stat_cnt_q <= stat_cnt_q + 32'd1;
      stat_zero_q <= zero_sum[32] ? '1 : zero_sum[31:0];
    end
  end

  assign stat_cnt  = stat_cnt_q;
  assign stat_zero = stat_zero_q;
`endif
endmodule
